clock_enable_gen: RTL and testbench

//  Parametrised multi-channel clock-enable generator. Replaces free-running divider taps.

---
 rtl/clock_enable_gen.sv | 135 +++++++++++++
 tb/tb_clock_enable_gen.sv | 186 ++++++++++++++++++
 2 files changed

// File: rtl/clock_enable_gen.sv
// clock_enable_gen: NUM_CH programmable clock-enable dividers, each producing a tick and a square wave.
// Optional macro CLKDIV_CASCADE_EN: channel k>0 advances only on channel k-1 terminal edges.
module clock_enable_gen #(
   parameter int                      NUM_CH    = 3,
   parameter int                      DIV_W     = 27,
   parameter logic [NUM_CH*DIV_W-1:0] INIT_DIVS = {27'd100000000, 27'd100000, 27'd4}
) (
   input  logic              clk,
   input  logic              clr,
   input  logic              en,
   input  logic              sync,
   input  logic              cfg_valid,
   output logic              cfg_ready,
   input  logic [2:0]        cfg_ch,
   input  logic [DIV_W-1:0]  cfg_div,
   output logic [NUM_CH-1:0] tick,
   output logic [NUM_CH-1:0] sq
);

   logic [DIV_W-1:0]  cnt_q [NUM_CH];
   logic [DIV_W-1:0]  cnt_d [NUM_CH];
   logic [DIV_W-1:0]  div_q [NUM_CH];
   logic [DIV_W-1:0]  div_d [NUM_CH];
   logic [NUM_CH-1:0] tick_q, tick_d;
   logic [NUM_CH-1:0] sq_q, sq_d;
   logic              pend_valid_q, pend_valid_d;
   logic [2:0]        pend_ch_q, pend_ch_d;
   logic [DIV_W-1:0]  pend_div_q, pend_div_d;
   logic [NUM_CH-1:0] at_term_s, step_s, hit_s, apply_s;

   always_comb begin
      for (int k = 0; k < NUM_CH; k++) begin
         at_term_s[k] = (cnt_q[k] == (div_q[k] - DIV_W'(1)));
         hit_s[k]     = pend_valid_q && (pend_ch_q == 3'(k));
      end
   end

   // Enabled-edge qualifier; in cascade mode it chains through lower channels' terminal counts.
   always_comb begin : step_gen
      logic chain;
      chain = en;
      for (int k = 0; k < NUM_CH; k++) begin
         step_s[k] = chain;
`ifdef CLKDIV_CASCADE_EN
         chain = chain & at_term_s[k];
`else
         chain = en;
`endif
      end
   end

   // Per-channel next state: sync beats everything, a pending ratio lands only at a period boundary.
   always_comb begin
      for (int k = 0; k < NUM_CH; k++) begin
         cnt_d[k]   = cnt_q[k];
         div_d[k]   = div_q[k];
         tick_d[k]  = 1'b0;
         apply_s[k] = 1'b0;
         if (sync) begin
            cnt_d[k]   = '0;
            apply_s[k] = hit_s[k];
            if (hit_s[k]) begin
               div_d[k] = pend_div_q;
            end else begin
               div_d[k] = div_q[k];
            end
         end else if (hit_s[k] && !en) begin
            cnt_d[k]   = '0;
            div_d[k]   = pend_div_q;
            apply_s[k] = 1'b1;
         end else if (step_s[k] && at_term_s[k]) begin
            cnt_d[k]   = '0;
            tick_d[k]  = 1'b1;
            apply_s[k] = hit_s[k];
            if (hit_s[k]) begin
               div_d[k] = pend_div_q;
            end else begin
               div_d[k] = div_q[k];
            end
         end else if (step_s[k]) begin
            cnt_d[k] = cnt_q[k] + DIV_W'(1);
         end else begin
            cnt_d[k] = cnt_q[k];
         end

         if (sync) begin
            sq_d[k] = 1'b0;
         end else begin
            sq_d[k] = (cnt_d[k] < (div_d[k] >> 1));
         end
      end
   end

   always_comb begin
      pend_valid_d = pend_valid_q;
      pend_ch_d    = pend_ch_q;
      pend_div_d   = pend_div_q;
      if (|apply_s) begin
         pend_valid_d = 1'b0;
      end else if (cfg_valid && !pend_valid_q && (int'(cfg_ch) < NUM_CH)) begin
         pend_valid_d = 1'b1;
         pend_ch_d    = cfg_ch;
         pend_div_d   = (cfg_div == '0) ? DIV_W'(1) : cfg_div;
      end else begin
         pend_valid_d = pend_valid_q;
      end
   end

   always_ff @(posedge clk or posedge clr) begin
      if (clr) begin
         for (int k = 0; k < NUM_CH; k++) begin
            cnt_q[k] <= '0;
            div_q[k] <= INIT_DIVS[k*DIV_W +: DIV_W];
         end
         tick_q       <= '0;
         sq_q         <= '0;
         pend_valid_q <= 1'b0;
         pend_ch_q    <= 3'd0;
         pend_div_q   <= '0;
      end else begin
         cnt_q        <= cnt_d;
         div_q        <= div_d;
         tick_q       <= tick_d;
         sq_q         <= sq_d;
         pend_valid_q <= pend_valid_d;
         pend_ch_q    <= pend_ch_d;
         pend_div_q   <= pend_div_d;
      end
   end

   assign tick      = tick_q;
   assign sq        = sq_q;
   assign cfg_ready = ~pend_valid_q;

endmodule

// File: tb/tb_clock_enable_gen.sv
// Directed self-checking bench for clock_enable_gen (3 channels, small ratios).
module tb_clock_enable_gen;
   localparam int NUM_CH = 3;
   localparam int DIV_W  = 27;
`ifdef CLKDIV_CASCADE_EN
   localparam logic [NUM_CH*DIV_W-1:0] INIT = {27'd3, 27'd2, 27'd2};
`else
   localparam logic [NUM_CH*DIV_W-1:0] INIT = {27'd10, 27'd5, 27'd4};
`endif

   logic              clk, clr, en, sync, cfg_valid, cfg_ready;
   logic [2:0]        cfg_ch;
   logic [DIV_W-1:0]  cfg_div;
   logic [NUM_CH-1:0] tick, sq;
   int                total, bad;

   clock_enable_gen #(.NUM_CH(NUM_CH), .DIV_W(DIV_W), .INIT_DIVS(INIT)) dut (
      .clk(clk), .clr(clr), .en(en), .sync(sync),
      .cfg_valid(cfg_valid), .cfg_ready(cfg_ready), .cfg_ch(cfg_ch), .cfg_div(cfg_div),
      .tick(tick), .sq(sq)
   );

   initial begin
      clk = 1'b0;
      forever #5 clk = ~clk;
   end

   task automatic next_edge();
      @(posedge clk);
      #1;
   endtask

   task automatic do_reset();
      clr = 1'b1; en = 1'b0; sync = 1'b0; cfg_valid = 1'b0; cfg_ch = 3'd0; cfg_div = 27'd0;
      next_edge();
      clr = 1'b0;
   endtask

   task automatic test_reset();
      clr = 1'b1; en = 1'b1; sync = 1'b0; cfg_valid = 1'b1; cfg_ch = 3'd0; cfg_div = 27'd7;
      next_edge();
      next_edge();
      total++; if (tick !== 3'b000) begin bad++; $display("FAIL reset_tick got=%b exp=000", tick); end
      total++; if (sq !== 3'b000) begin bad++; $display("FAIL reset_sq got=%b exp=000", sq); end
      total++; if (cfg_ready !== 1'b1) begin bad++; $display("FAIL reset_ready got=%b exp=1", cfg_ready); end
      cfg_valid = 1'b0;
   endtask

   task automatic test_count();
      logic [2:0] exp_t, exp_s;
      do_reset();
      en = 1'b1;
      for (int c = 1; c <= 40; c++) begin
         next_edge();
         exp_t = {c % 10 == 0, c % 5 == 0, c % 4 == 0};
         exp_s = {(c % 10) < 5, (c % 5) < 2, (c % 4) < 2};
         total++; if (tick !== exp_t) begin bad++; $display("FAIL count_tick c=%0d got=%b exp=%b", c, tick, exp_t); end
         total++; if (sq !== exp_s) begin bad++; $display("FAIL count_sq c=%0d got=%b exp=%b", c, sq, exp_s); end
      end
   endtask

   task automatic test_cfg_apply();
      logic [2:0] exp_t;
      logic       exp_r, exp_s1;
      do_reset();
      en = 1'b1; cfg_ch = 3'd1; cfg_div = 27'd3;
      for (int c = 1; c <= 20; c++) begin
         next_edge();
         exp_t  = {c % 10 == 0, (c == 5) || (c > 5 && (c - 5) % 3 == 0), c % 4 == 0};
         exp_r  = !(c == 3 || c == 4);
         exp_s1 = (c <= 5) ? ((c % 5) < 2) : (((c - 5) % 3) == 0);
         total++; if (tick !== exp_t) begin bad++; $display("FAIL cfg_tick c=%0d got=%b exp=%b", c, tick, exp_t); end
         total++; if (cfg_ready !== exp_r) begin bad++; $display("FAIL cfg_ready c=%0d got=%b exp=%b", c, cfg_ready, exp_r); end
         total++; if (sq[1] !== exp_s1) begin bad++; $display("FAIL cfg_sq1 c=%0d got=%b exp=%b", c, sq[1], exp_s1); end
         if (c == 2) cfg_valid = 1'b1;
         if (c == 3) cfg_valid = 1'b0;
      end
   endtask

   task automatic test_cfg_edges();
      logic [2:0] exp_t;
      logic       exp_r, exp_s0;
      do_reset();
      en = 1'b1; cfg_ch = 3'd5; cfg_div = 27'd7; cfg_valid = 1'b1;
      for (int c = 1; c <= 24; c++) begin
         next_edge();
         exp_t  = {c % 10 == 0, c % 5 == 0, (c >= 16) || (c % 4 == 0)};
         exp_r  = !(c >= 13 && c <= 15);
         exp_s0 = (c >= 16) ? 1'b0 : ((c % 4) < 2);
         total++; if (tick !== exp_t) begin bad++; $display("FAIL edge_tick c=%0d got=%b exp=%b", c, tick, exp_t); end
         total++; if (cfg_ready !== exp_r) begin bad++; $display("FAIL edge_ready c=%0d got=%b exp=%b", c, cfg_ready, exp_r); end
         total++; if (sq[0] !== exp_s0) begin bad++; $display("FAIL edge_sq0 c=%0d got=%b exp=%b", c, sq[0], exp_s0); end
         if (c == 12) begin cfg_ch = 3'd0; cfg_div = 27'd0; end
         if (c == 13) cfg_valid = 1'b0;
      end
   endtask

   task automatic test_en_sync();
      logic [2:0] exp_t, exp_s;
      int         e;
      do_reset();
      e = 0;
      for (int i = 1; i <= 30; i++) begin
         en = !(i >= 7 && i <= 13);
         next_edge();
         if (en) e++;
         exp_t = en ? {e % 10 == 0, e % 5 == 0, e % 4 == 0} : 3'b000;
         exp_s = {(e % 10) < 5, (e % 5) < 2, (e % 4) < 2};
         total++; if (tick !== exp_t) begin bad++; $display("FAIL en_tick i=%0d got=%b exp=%b", i, tick, exp_t); end
         total++; if (sq !== exp_s) begin bad++; $display("FAIL en_sq i=%0d got=%b exp=%b", i, sq, exp_s); end
      end
      en = 1'b1; cfg_valid = 1'b1; cfg_ch = 3'd2; cfg_div = 27'd6;
      next_edge();
      total++; if (tick !== 3'b001) begin bad++; $display("FAIL presync_tick got=%b exp=001", tick); end
      total++; if (cfg_ready !== 1'b0) begin bad++; $display("FAIL presync_ready got=%b exp=0", cfg_ready); end
      cfg_valid = 1'b0; sync = 1'b1;
      next_edge();
      sync = 1'b0;
      total++; if (tick !== 3'b000) begin bad++; $display("FAIL sync_tick got=%b exp=000", tick); end
      total++; if (sq !== 3'b000) begin bad++; $display("FAIL sync_sq got=%b exp=000", sq); end
      total++; if (cfg_ready !== 1'b1) begin bad++; $display("FAIL sync_ready got=%b exp=1", cfg_ready); end
      for (int s = 1; s <= 12; s++) begin
         next_edge();
         exp_t = {s % 6 == 0, s % 5 == 0, s % 4 == 0};
         exp_s = {(s % 6) < 3, (s % 5) < 2, (s % 4) < 2};
         total++; if (tick !== exp_t) begin bad++; $display("FAIL postsync_tick s=%0d got=%b exp=%b", s, tick, exp_t); end
         total++; if (sq !== exp_s) begin bad++; $display("FAIL postsync_sq s=%0d got=%b exp=%b", s, sq, exp_s); end
      end
   endtask

   task automatic test_clr_pending();
      logic [2:0] exp_t, exp_s;
      do_reset();
      en = 1'b1; cfg_valid = 1'b1; cfg_ch = 3'd2; cfg_div = 27'd20;
      for (int c = 1; c <= 3; c++) begin
         next_edge();
         cfg_valid = 1'b0;
         total++; if (cfg_ready !== 1'b0) begin bad++; $display("FAIL pend_ready c=%0d got=%b exp=0", c, cfg_ready); end
      end
      clr = 1'b1;
      #2;
      total++; if (tick !== 3'b000) begin bad++; $display("FAIL aclr_tick got=%b exp=000", tick); end
      total++; if (sq !== 3'b000) begin bad++; $display("FAIL aclr_sq got=%b exp=000", sq); end
      total++; if (cfg_ready !== 1'b1) begin bad++; $display("FAIL aclr_ready got=%b exp=1", cfg_ready); end
      next_edge();
      clr = 1'b0; en = 1'b1;
      for (int c = 1; c <= 20; c++) begin
         next_edge();
         exp_t = {c % 10 == 0, c % 5 == 0, c % 4 == 0};
         exp_s = {(c % 10) < 5, (c % 5) < 2, (c % 4) < 2};
         total++; if (tick !== exp_t) begin bad++; $display("FAIL postclr_tick c=%0d got=%b exp=%b", c, tick, exp_t); end
         total++; if (sq !== exp_s) begin bad++; $display("FAIL postclr_sq c=%0d got=%b exp=%b", c, sq, exp_s); end
         total++; if (cfg_ready !== 1'b1) begin bad++; $display("FAIL postclr_ready c=%0d got=%b exp=1", c, cfg_ready); end
      end
   endtask

   task automatic test_cascade();
      logic [2:0] exp_t, exp_s;
      do_reset();
      en = 1'b1;
      for (int c = 1; c <= 24; c++) begin
         next_edge();
         exp_t = {c % 12 == 0, c % 4 == 0, c % 2 == 0};
         exp_s = {((c / 4) % 3) == 0, ((c / 2) % 2) == 0, (c % 2) == 0};
         total++; if (tick !== exp_t) begin bad++; $display("FAIL casc_tick c=%0d got=%b exp=%b", c, tick, exp_t); end
         total++; if (sq !== exp_s) begin bad++; $display("FAIL casc_sq c=%0d got=%b exp=%b", c, sq, exp_s); end
      end
   endtask

   initial begin
      total = 0; bad = 0;
      clr = 1'b1; en = 1'b0; sync = 1'b0; cfg_valid = 1'b0; cfg_ch = 3'd0; cfg_div = 27'd0;
      test_reset();
`ifdef CLKDIV_CASCADE_EN
      test_cascade();
`else
      test_count();
      test_cfg_apply();
      test_cfg_edges();
      test_en_sync();
      test_clr_pending();
`endif
      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end
endmodule
